// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: single owner of the VRAM write port; clear > brush > host, registered writes.
// Optional pixel statistics counter enabled with VRAM_ARB_STATS_EN.
module vram_write_arbiter #(
  parameter int DISPLAY_WIDTH = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_W = 16,
  parameter int BRUSH = 3,
  parameter logic [VRAM_W-1:0] CLEAR_COLOR = 16'h0000,
  localparam int VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT,
  localparam int AW = $clog2(VRAM_L),
  localparam int XW = $clog2(DISPLAY_WIDTH),
  localparam int YW = $clog2(DISPLAY_HEIGHT)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              touch_valid,
  input  logic [XW-1:0]     touch_x,
  input  logic [YW-1:0]     touch_y,
  input  logic [VRAM_W-1:0] draw_color,
  input  logic              host_req,
  input  logic [AW-1:0]     host_addr,
  input  logic [VRAM_W-1:0] host_data,
  output logic              host_gnt,
  output logic              busy,
  output logic              vram_wr_ena,
  output logic [AW-1:0]     vram_wr_addr,
  output logic [VRAM_W-1:0] vram_wr_data
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       pixels_painted
`endif
);
  localparam int H = BRUSH/2;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BRUSH} state_t;
  state_t state, state_d;
  logic [AW-1:0] clr_cnt, clr_d, addr_d, pix_addr;
  logic [XW-1:0] bx, bx_d, lx, lx_d;
  logic [YW-1:0] by, by_d, ly, ly_d;
  logic [VRAM_W-1:0] bc, bc_d, lc, lc_d, data_d;
  logic [2:0] ox, ox_d, oy, oy_d;
  logic lv, lv_d, ena_d, in_x, in_y, dup, last_px;
  logic [XW:0] sx;
  logic [YW:0] sy;
  // Offsets run 0..BRUSH-1; subtracting H after the range test avoids signed wrap at the edges.
  assign sx = {1'b0, bx} + (XW+1)'(ox);
  assign sy = {1'b0, by} + (YW+1)'(oy);
  assign in_x = sx >= (XW+1)'(H) && sx < (XW+1)'(DISPLAY_WIDTH + H);
  assign in_y = sy >= (YW+1)'(H) && sy < (YW+1)'(DISPLAY_HEIGHT + H);
  assign pix_addr = AW'(sy - (YW+1)'(H)) * AW'(DISPLAY_WIDTH) + AW'(sx - (XW+1)'(H));
  assign dup = lv && touch_x == lx && touch_y == ly && draw_color == lc;
  assign last_px = ox == 3'(BRUSH-1) && oy == 3'(BRUSH-1);
  assign host_gnt = state == S_IDLE && !clear_req && !touch_valid;
  assign busy = state != S_IDLE;
  always_comb begin
    state_d = state;
    clr_d = clr_cnt;
    bx_d = bx;
    by_d = by;
    bc_d = bc;
    lx_d = lx;
    ly_d = ly;
    lc_d = lc;
    lv_d = lv;
    ox_d = ox;
    oy_d = oy;
    ena_d = 1'b0;
    addr_d = vram_wr_addr;
    data_d = vram_wr_data;
    case (state)
      S_CLEAR: begin
        ena_d = 1'b1;
        addr_d = clr_cnt;
        data_d = CLEAR_COLOR;
        lv_d = 1'b0;
        clr_d = clr_cnt - 1'b1;
        state_d = clr_cnt == '0 ? S_IDLE : S_CLEAR;
      end
      S_IDLE: begin
        if (clear_req) begin
          clr_d = AW'(VRAM_L-1);
          state_d = S_CLEAR;
        end else if (touch_valid) begin
          if (!dup) begin
            bx_d = touch_x;
            by_d = touch_y;
            bc_d = draw_color;
            ox_d = '0;
            oy_d = '0;
            state_d = S_BRUSH;
          end
        end else if (host_req) begin
          ena_d = {1'b0, host_addr} < (AW+1)'(VRAM_L);
          addr_d = host_addr;
          data_d = host_data;
        end
      end
      S_BRUSH: begin
        ena_d = in_x && in_y;
        addr_d = pix_addr;
        data_d = bc;
        ox_d = ox == 3'(BRUSH-1) ? 3'd0 : ox + 3'd1;
        oy_d = ox == 3'(BRUSH-1) ? oy + 3'd1 : oy;
        if (clear_req) begin
          clr_d = AW'(VRAM_L-1);
          state_d = S_CLEAR;
        end else if (last_px) begin
          lx_d = bx;
          ly_d = by;
          lc_d = bc;
          lv_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
      clr_cnt <= AW'(VRAM_L-1);
      bx <= '0;
      by <= '0;
      bc <= '0;
      lx <= '0;
      ly <= '0;
      lc <= '0;
      lv <= 1'b0;
      ox <= '0;
      oy <= '0;
      vram_wr_ena <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
    end else begin
      state <= state_d;
      clr_cnt <= clr_d;
      bx <= bx_d;
      by <= by_d;
      bc <= bc_d;
      lx <= lx_d;
      ly <= ly_d;
      lc <= lc_d;
      lv <= lv_d;
      ox <= ox_d;
      oy <= oy_d;
      vram_wr_ena <= ena_d;
      vram_wr_addr <= addr_d;
      vram_wr_data <= data_d;
    end
  end
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (state == S_CLEAR && clr_cnt == '0) cnt <= '0;
    else if (state == S_BRUSH && ena_d && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign pixels_painted = cnt;
`endif
endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Sole owner of the block_ram VRAM write port for the etch-a-sketch display.
- Sequences three write sources:
  - full-screen clear sweep (power-up and on request),
  - square-brush painting from the touch controller,
  - single-pixel writes from a generic host requester.
- Fixed priority: clear > brush > host. All VRAM write outputs are registered.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row (x range).
- DISPLAY_HEIGHT, 320, rows (y range).
- VRAM_W, 16, pixel width (ILI9341 RGB565).
- BRUSH, 3, brush side length in pixels; odd, 1..7.
- CLEAR_COLOR, 16'h0000, fill value for clear (BLACK).
- Derived localparams:
  - VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT
  - AW = $clog2(VRAM_L)
  - XW = $clog2(DISPLAY_WIDTH)
  - YW = $clog2(DISPLAY_HEIGHT)

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- clear_req  in  1  single-cycle request to clear the screen.
- touch_valid  in  1  touch sample valid (level).
- touch_x  in  XW  touch column.
- touch_y  in  YW  touch row.
- draw_color  in  VRAM_W  brush colour, sampled at brush start.
- host_req  in  1  host single-pixel write request.
- host_addr  in  AW  host linear address.
- host_data  in  VRAM_W  host pixel data.
- host_gnt  out  1  combinational grant; a write is accepted when host_req & host_gnt.
- busy  out  1  high in S_CLEAR or S_BRUSH.
- vram_wr_ena  out  1  VRAM write enable.
- vram_wr_addr  out  AW  VRAM write address.
- vram_wr_data  out  VRAM_W  VRAM write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_CLEAR, clr_cnt=VRAM_L-1.
  - vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0, busy=1.
  - last-painted register invalid.
- Address rule: addr = y*DISPLAY_WIDTH + x, computed at AW bits with zero-extended operands; no truncation for in-range inputs.
- S_CLEAR:
  - Each cycle writes CLEAR_COLOR at clr_cnt, then decrements.
  - The cycle that writes address 0 goes to S_IDLE.
  - Takes exactly VRAM_L write cycles.
  - Invalidates the last-painted register.
  - clear_req during S_CLEAR is ignored (no restart).
- S_IDLE, evaluated in priority order:
  - clear_req=1: load clr_cnt=VRAM_L-1, go to S_CLEAR; first clear write appears on the next cycle.
  - Otherwise touch_valid=1 and (x,y,color) differs from the last-painted value: latch x, y and draw_color, clear the offset counters, go to S_BRUSH.
  - Otherwise touch_valid=1 and identical to last painted: stay in S_IDLE, issue no write (duplicate suppression).
  - host_gnt = (state==S_IDLE) & ~clear_req & ~touch_valid.
    - On an accepted host write, vram_wr_* = host_addr/host_data with ena=1 on the next cycle.
    - host_addr >= VRAM_L is dropped (ena=0) but still granted.
  - Otherwise vram_wr_ena=0 next cycle.
- S_BRUSH:
  - Iterates dy,dx each over -(BRUSH/2)..+(BRUSH/2), dx fastest, one pixel per cycle: BRUSH*BRUSH cycles.
  - Pixels with x+dx or y+dy outside [0,WIDTH-1] / [0,HEIGHT-1] get vram_wr_ena=0 but still consume their cycle (fixed latency).
  - Edge cases: no signed wrap, no row spill.
  - After the last pixel: record (x,y,color) as last painted, go to S_IDLE.
  - clear_req during S_BRUSH: the current pixel completes, the remainder is aborted, go to S_CLEAR next cycle. Last painted is not updated.
  - touch_valid changes during S_BRUSH are ignored; the next sample is taken in S_IDLE.
- Latency:
  - Request in S_IDLE to first VRAM write: 1 cycle for host, 2 cycles for brush (1 latch + 1 output register).
- Simultaneous clear_req + touch_valid + host_req in S_IDLE: clear wins. Touch and host are not serviced; host sees host_gnt=0.
- Reset deasserted mid-operation: always restarts with a full clear.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- When defined:
  - Adds output port pixels_painted (16 bits).
  - Counts brush cycles with vram_wr_ena=1, saturating at 16'hFFFF.
  - Resets to 0 on rst and when S_CLEAR completes.
- When undefined: no port and no counter; behaviour otherwise identical.

Test Plan:
- Reset release:
  - Expect exactly 76800 consecutive writes, addr 76799 down to 0, data 16'h0000, busy=1 throughout.
  - Then busy=0 and host_gnt=1.
- touch (x=100,y=50), color 16'hF81F, after clear:
  - Expect 9 writes starting 2 cycles later, addrs 11859,11860,11861, 12099,12100,12101, 12339,12340,12341, all data 16'hF81F.
  - Then touch held constant produces no further writes.
- touch (x=0,y=0), BRUSH=3:
  - Expect 9 cycles with ena pattern 0,0,0, 0,1,1, 0,1,1.
  - Enabled addrs 0,1,240,241.
- host_req with addr 1234, data 16'h07E0 in S_IDLE and touch_valid=0:
  - host_gnt=1; next cycle ena=1, addr 1234, data 16'h07E0.
  - With touch_valid=1 in the same cycle: host_gnt=0 and the brush starts.
- clear_req on the 4th brush cycle:
  - 4 brush writes total, then clear begins at addr 76799 the next cycle.
  - The same touch afterward repaints all 9 pixels.
- rst pulsed low mid-clear at counter 40000:
  - Outputs immediately zero.
  - After release, clear restarts from 76799.
